// File: rtl/hcu_pkg.sv
// Shared definitions for the pipeline hazard control unit: FSM encoding,
// default parameters and the per-stage control words applied by the sequencer.
package hcu_pkg;

   typedef enum logic {
      ST_RUN     = 1'b0,
      ST_MD_BUSY = 1'b1
   } hcu_state_e;

   localparam int MD_LATENCY_DEF = 4;
   localparam int CNT_W_DEF      = 16;
   localparam int MD_CNT_W       = 4;

   typedef struct packed {
      logic pc_write;
      logic if_id_write;
      logic if_id_flush;
      logic id_ex_write;
      logic id_ex_bubble;
      logic ex_mem_write;
      logic mem_wb_bubble;
   } ctl_t;

   // CTL_NOP is the all-quiet word: nothing loads and nothing is bubbled.
   localparam ctl_t CTL_NOP       = 7'b000_0000;
   localparam ctl_t CTL_RUN       = 7'b110_1010;
   localparam ctl_t CTL_MEM_WAIT  = 7'b000_0001;
   localparam ctl_t CTL_MD_FREEZE = 7'b000_0010;
   localparam ctl_t CTL_FLUSH     = 7'b111_1110;
   localparam ctl_t CTL_LOAD_USE  = 7'b000_1110;

   function automatic logic load_use_hit(
      input logic       memread,
      input logic [4:0] writereg,
      input logic [4:0] rs,
      input logic [4:0] rt,
      input logic       uses_rt
   );
      load_use_hit = memread && (writereg != 5'd0) &&
                     ((writereg == rs) || (uses_rt && (writereg == rt)));
   endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// Hazard-unit bus: pipeline status in, stage load/bubble controls and
// performance counters out.
interface hazard_control_unit_if #(
   parameter int CNT_W = 16
);

   logic             ID_EX_memread;
   logic [4:0]       ID_EX_writereg;
   logic [4:0]       IF_ID_rs;
   logic [4:0]       IF_ID_rt;
   logic             IF_ID_uses_rt;
   logic             EX_branch_taken;
   logic             EX_md_start;
   logic             MEM_access;
   logic             mem_ready;

   logic             PC_write;
   logic             IF_ID_write;
   logic             IF_ID_flush;
   logic             ID_EX_write;
   logic             ID_EX_bubble;
   logic             EX_MEM_write;
   logic             MEM_WB_bubble;
   logic             md_busy;
   logic             md_done;
   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] flush_count;

   modport master (
      output ID_EX_memread, ID_EX_writereg, IF_ID_rs, IF_ID_rt, IF_ID_uses_rt,
             EX_branch_taken, EX_md_start, MEM_access, mem_ready,
      input  PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_bubble,
             EX_MEM_write, MEM_WB_bubble, md_busy, md_done,
             stall_cycles, flush_count
   );

   modport slave (
      input  ID_EX_memread, ID_EX_writereg, IF_ID_rs, IF_ID_rt, IF_ID_uses_rt,
             EX_branch_taken, EX_md_start, MEM_access, mem_ready,
      output PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_bubble,
             EX_MEM_write, MEM_WB_bubble, md_busy, md_done,
             stall_cycles, flush_count
   );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter for performance readout; sticks at all-ones and
// never wraps.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_inc,
   output logic [W-1:0] o_count
);

   logic [W-1:0] r_count;

   // Count qualifying cycles until the all-ones ceiling is reached.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= {W{1'b0}};
      end else if (i_inc && (r_count != {W{1'b1}})) begin
         r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
      end else begin
         r_count <= r_count;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencer: resolves mem-wait, mul/div freeze, branch flush and
// load-use hazards into per-stage load/bubble controls, with stall/flush counters.
module hazard_control_unit
   import hcu_pkg::*;
#(
   parameter int MD_LATENCY = MD_LATENCY_DEF,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   hazard_control_unit_if.slave  bus
);

   localparam logic [MD_CNT_W-1:0] MD_RELOAD = MD_CNT_W'(MD_LATENCY - 2);

   hcu_state_e          r_state;
   hcu_state_e          w_state_nxt;
   logic [MD_CNT_W-1:0] r_md_cnt;
   logic [MD_CNT_W-1:0] w_md_cnt_nxt;
   ctl_t                w_ctl;
   logic                w_md_busy;
   logic                w_md_done;
   logic                w_mem_wait;
   logic                w_load_use;
   logic [CNT_W-1:0]    w_stall_cnt;
   logic [CNT_W-1:0]    w_flush_cnt;

   assign w_mem_wait = bus.MEM_access && !bus.mem_ready;
   assign w_load_use = load_use_hit(bus.ID_EX_memread, bus.ID_EX_writereg,
                                    bus.IF_ID_rs, bus.IF_ID_rt, bus.IF_ID_uses_rt);

   // FSM state and mul/div residency counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_RUN;
         r_md_cnt <= {MD_CNT_W{1'b0}};
      end else begin
         r_state  <= w_state_nxt;
         r_md_cnt <= w_md_cnt_nxt;
      end
   end

   // Hazard priority: mem wait > mul/div freeze > branch flush > load-use.
   always_comb begin
      w_state_nxt  = r_state;
      w_md_cnt_nxt = r_md_cnt;
      w_ctl        = CTL_RUN;
      w_md_busy    = 1'b0;
      w_md_done    = 1'b0;
      if (rst) begin
         w_ctl        = CTL_NOP;
         w_state_nxt  = ST_RUN;
         w_md_cnt_nxt = {MD_CNT_W{1'b0}};
      end else if (w_mem_wait) begin
         // A pending branch stays in EX and is taken once the wait clears.
         w_ctl     = CTL_MEM_WAIT;
         w_md_busy = (r_state == ST_MD_BUSY);
      end else begin
         case (r_state)
            ST_MD_BUSY: begin
               if (r_md_cnt != {MD_CNT_W{1'b0}}) begin
                  w_ctl        = CTL_MD_FREEZE;
                  w_md_busy    = 1'b1;
                  w_md_cnt_nxt = r_md_cnt - {{(MD_CNT_W-1){1'b0}}, 1'b1};
               end else begin
                  w_ctl       = CTL_RUN;
                  w_md_done   = 1'b1;
                  w_state_nxt = ST_RUN;
               end
            end
            ST_RUN: begin
               if (bus.EX_md_start) begin
                  w_ctl        = CTL_MD_FREEZE;
                  w_md_busy    = 1'b1;
                  w_state_nxt  = ST_MD_BUSY;
                  w_md_cnt_nxt = MD_RELOAD;
               end else if (bus.EX_branch_taken) begin
                  w_ctl = CTL_FLUSH;
               end else if (w_load_use) begin
                  w_ctl = CTL_LOAD_USE;
               end else begin
                  w_ctl = CTL_RUN;
               end
            end
            default: begin
               w_ctl        = CTL_RUN;
               w_state_nxt  = ST_RUN;
               w_md_cnt_nxt = {MD_CNT_W{1'b0}};
            end
         endcase
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk     (clk),
      .rst     (rst),
      .i_inc   (!w_ctl.pc_write),
      .o_count (w_stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk     (clk),
      .rst     (rst),
      .i_inc   (w_ctl.if_id_flush),
      .o_count (w_flush_cnt)
   );

   assign bus.PC_write      = w_ctl.pc_write;
   assign bus.IF_ID_write   = w_ctl.if_id_write;
   assign bus.IF_ID_flush   = w_ctl.if_id_flush;
   assign bus.ID_EX_write   = w_ctl.id_ex_write;
   assign bus.ID_EX_bubble  = w_ctl.id_ex_bubble;
   assign bus.EX_MEM_write  = w_ctl.ex_mem_write;
   assign bus.MEM_WB_bubble = w_ctl.mem_wb_bubble;
   assign bus.md_busy       = w_md_busy;
   assign bus.md_done       = w_md_done;
   assign bus.stall_cycles  = w_stall_cnt;
   assign bus.flush_count   = w_flush_cnt;

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Pipeline sequencer for the 5-stage CPU. Decides every cycle which pipeline registers load, hold or take a bubble.
- Covers four cases:
  - load-use stalls, since forwarding cannot cover a load result needed in the next cycle;
  - taken-branch flushes;
  - the multi-cycle mul/div freeze;
  - data-memory wait states.
- Sits beside the forwarding unit. It drives the PC and the IF_ID, ID_EX, EX_MEM and MEM_WB enable/bubble controls, and keeps saturating stall and flush counters for performance readout.

Parameters:
- MD_LATENCY, 4: total cycles a mul/div instruction occupies EX. Legal range 2..15.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-high reset.
- ID_EX_memread  in  1  instruction in EX is a load.
- ID_EX_writereg  in  5  destination register of the instruction in EX.
- IF_ID_rs  in  5  rs of the instruction in ID.
- IF_ID_rt  in  5  rt of the instruction in ID.
- IF_ID_uses_rt  in  1  instruction in ID reads rt.
- EX_branch_taken  in  1  branch resolved taken in EX this cycle.
- EX_md_start  in  1  mul/div instruction is in EX this cycle (level).
- MEM_access  in  1  instruction in MEM accesses data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- PC_write  out  1  PC loads its next value.
- IF_ID_write  out  1  IF_ID loads.
- IF_ID_flush  out  1  IF_ID is cleared to a NOP.
- ID_EX_write  out  1  ID_EX loads.
- ID_EX_bubble  out  1  ID_EX loads a NOP.
- EX_MEM_write  out  1  EX_MEM loads.
- MEM_WB_bubble  out  1  MEM_WB loads a NOP.
- md_busy  out  1  mul/div freeze is active.
- md_done  out  1  one-cycle pulse in the mul/div release cycle.
- stall_cycles  out  CNT_W  saturating count of cycles with PC_write=0.
- flush_count  out  CNT_W  saturating count of cycles with IF_ID_flush=1.

Behaviour:
- FSM states: RUN and MD_BUSY. Down-counter md_cnt is 4 bits wide.
- Reset: async on rst high.
  - state=RUN, md_cnt=0, both counters=0.
  - While rst is high, all *_write outputs are 0 and all flush/bubble/md outputs are 0.
- Default (RUN, no hazard): all writes=1, all flush/bubble=0, md_busy=0, md_done=0.
- Priority, highest first: mem wait > mul/div freeze > branch flush > load-use. Exactly one case applies per cycle.
- Mem wait, condition MEM_access && !mem_ready:
  - Outputs: PC_write, IF_ID_write, ID_EX_write, EX_MEM_write = 0; MEM_WB_bubble=1; IF_ID_flush=0, ID_EX_bubble=0.
  - The state and md_cnt do not change.
  - EX_branch_taken is ignored. The branch stays held in EX and is acted on in the first non-wait cycle.
- Mul/div, in RUN with EX_md_start=1:
  - Outputs: PC_write, IF_ID_write, ID_EX_write = 0; EX_MEM_write=1; ID_EX_bubble=0; md_busy=1.
  - Next state MD_BUSY with md_cnt=MD_LATENCY-2.
  - In MD_BUSY with md_cnt!=0: same freeze outputs; md_cnt decrements.
  - In MD_BUSY with md_cnt==0: md_done=1, md_busy=0, all writes=1; next state RUN.
  - EX_md_start is ignored while in MD_BUSY.
  - While frozen, EX_MEM_write=1 lets the MEM and WB stages drain. The mul/div result is valid in the release cycle.
  - MD_LATENCY=2 gives exactly one frozen cycle followed by the release cycle.
- Branch, EX_branch_taken in RUN:
  - Outputs: PC_write=1 (redirect), IF_ID_flush=1, ID_EX_bubble=1.
  - Any concurrent load-use hazard is discarded, because the instruction in ID is on the wrong path.
- Load-use: condition is ID_EX_memread && ID_EX_writereg!=0 && (ID_EX_writereg==IF_ID_rs || (IF_ID_uses_rt && ID_EX_writereg==IF_ID_rt)).
  - Outputs: PC_write=0, IF_ID_write=0, ID_EX_bubble=1, other writes=1.
  - Lasts exactly one cycle. The next cycle sees the load in MEM and no longer matches.
- ID_EX_bubble and ID_EX_write are never both relevant in a hold: a hold keeps ID_EX_bubble=0.
- Counters:
  - Registered; each increments by 1 per qualifying cycle.
  - Each saturates at 2^CNT_W-1 and never wraps.
  - Reset clears them mid-count.
- Reset asserted mid MD_BUSY returns the FSM to RUN immediately. No md_done pulse is produced.

Decomposition:
- Shared package hcu_pkg:
  - state encoding (RUN=0, MD_BUSY=1);
  - MD_LATENCY default;
  - the NOP encoding used by the flush/bubble logic.
- One sub-module, sat_counter (parameter W, inputs inc/clk/rst), instantiated twice: once for stall_cycles, once for flush_count.

Test Plan:
- Load-use: ID_EX_memread=1, ID_EX_writereg=5, IF_ID_rs=5. Expect exactly 1 cycle of PC_write=0, IF_ID_write=0, ID_EX_bubble=1; stall_cycles goes 0 to 1. The same case with writereg=0 gives no stall.
- Branch and load-use together: EX_branch_taken=1 plus a load-use match. Expect IF_ID_flush=1, ID_EX_bubble=1, PC_write=1; flush_count=1; stall_cycles unchanged.
- Mul/div with MD_LATENCY=4 and EX_md_start held: expect md_busy=1 for 3 cycles, then the md_done pulse with all writes=1; stall_cycles=3.
- Mem wait during mul/div: mem_ready=0 for 2 cycles in the middle of MD_BUSY. md_cnt freezes, so the freeze lengthens from 3 to 5 cycles; EX_MEM_write=0 and MEM_WB_bubble=1 during the wait.
- Reset mid-operation: assert rst in the second MD_BUSY cycle. All outputs go to 0 asynchronously. After release, the state is RUN and the counters are 0.
- Saturation with CNT_W=4: hold a load-use hazard for 20 cycles. stall_cycles stops at 15.
